// File: rtl/weight_ram_controller_pkg.sv
// Shared definitions for the weight RAM controller and its neighbours
// (Network_Controller uses the same state encoding and layer count).
package weight_ram_controller_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } wrc_state_e;

  localparam int WRC_DATA_W    = 8;   // default weight width
  localparam int WRC_ADDR_W    = 10;  // default RAM address width
  localparam int WRC_LAYER_CNT = 3;   // number of real layers in the network

  // First RAM word of a layer: layer * neurons * inputs
  function automatic int unsigned wrc_layer_base(input logic [1:0]  layer,
                                                 input int unsigned n_neuron,
                                                 input int unsigned n_in);
    return 32'(layer) * n_neuron * n_in;
  endfunction

endpackage

// File: rtl/weight_ram_controller_if.sv
// Bus bundle between the weight RAM controller, the weight RAM and MultiSum.
// master = controller side, slave = RAM / consumer side.
interface weight_ram_controller_if
  import weight_ram_controller_pkg::*;
#(
  parameter int DATA_W = WRC_DATA_W,
  parameter int ADDR_W = WRC_ADDR_W
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic [DATA_W-1:0] ram_dout;
  logic [DATA_W-1:0] w_data;
  logic              w_valid;
  logic              w_ready;
  logic              w_last;
  logic [1:0]        neuron_idx;

  modport master (
    output ram_addr, ram_en,
    input  ram_dout,
    output w_data, w_valid, w_last, neuron_idx,
    input  w_ready
  );

  modport slave (
    input  ram_addr, ram_en,
    output ram_dout,
    input  w_data, w_valid, w_last, neuron_idx,
    output w_ready
  );
endinterface

// File: rtl/weight_ram_controller_skid.sv
// weight_skid_buf: one-entry skid buffer between the synchronous RAM read
// port and the weight consumer. Data returning from the RAM while the consumer
// stalls is parked here; the buffered entry always has output priority.
// full_next_o tells the issuer whether the slot will be occupied next cycle,
// so a read is only launched when its data is guaranteed a place to land.
module weight_skid_buf #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         full_next_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // Next occupancy of the slot from current occupancy, arrival and consumer ready
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (out_ready_i) begin
        if (in_valid_i) begin
          full_d = 1'b1;
          data_d = in_data_i;
        end else begin
          full_d = 1'b0;
        end
      end else begin
        full_d = 1'b1;
      end
    end else begin
      if (in_valid_i && !out_ready_i) begin
        full_d = 1'b1;
        data_d = in_data_i;
      end else begin
        full_d = 1'b0;
      end
    end
  end

  // Slot register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= {W{1'b0}};
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid_o = full_q | in_valid_i;
  assign out_data_o  = full_q ? data_q : in_data_i;
  assign full_next_o = full_d;

endmodule

// File: rtl/weight_ram_controller.sv
// weight_ram_controller: streams the N_NEURON*N_IN weights of one layer from
// a synchronous RAM to MultiSum over a valid/ready link, tagging each weight
// with its neuron index and an end-of-neuron flag.
// Optional build macro WEIGHT_RAM_LAYER_CHECK_EN: a start naming a layer
// beyond the last real layer performs no reads and just reports done.
module weight_ram_controller
  import weight_ram_controller_pkg::*;
#(
  parameter int DATA_W   = WRC_DATA_W,
  parameter int ADDR_W   = WRC_ADDR_W,
  parameter int N_IN     = 4,
  parameter int N_NEURON = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              layer,
  output logic                    done,
  output logic                    busy,
  weight_ram_controller_if.master bus
);

  localparam int                IN_W     = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int                PW       = DATA_W + 3;  // {neuron, last, data}
  localparam logic [IN_W-1:0]   IN_LAST  = IN_W'(N_IN - 1);
  localparam logic [IN_W-1:0]   IN_ONE   = {{(IN_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]        NRN_LAST = 2'(N_NEURON - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  wrc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [IN_W-1:0]   in_idx_q, in_idx_d;
  logic [1:0]        nrn_q, nrn_d;
  logic              skip_q, skip_d;
  // Tag of the read whose data is on ram_dout this cycle
  logic              rd_pend_q, rd_pend_d;
  logic              rd_last_q, rd_last_d;
  logic [1:0]        rd_nrn_q, rd_nrn_d;

  logic              issue_s;
  logic              last_issue_s;
  logic              fire_s;
  logic              final_beat_s;
  logic              sk_valid_s;
  logic              sk_full_next_s;
  logic [PW-1:0]     sk_in_s;
  logic [PW-1:0]     sk_out_s;
  logic [DATA_W-1:0] out_data_s;
  logic              out_last_s;
  logic [1:0]        out_nrn_s;

  // Read data carries the tag of the address it came from, so neuron_idx
  // and w_last follow the beat rather than the address counter.
  assign sk_in_s = {rd_nrn_q, rd_last_q, bus.ram_dout};

  weight_skid_buf #(.W(PW)) u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (rd_pend_q),
    .in_data_i  (sk_in_s),
    .out_ready_i(bus.w_ready),
    .out_valid_o(sk_valid_s),
    .out_data_o (sk_out_s),
    .full_next_o(sk_full_next_s)
  );

  assign out_nrn_s    = sk_out_s[PW-1 -: 2];
  assign out_last_s   = sk_out_s[DATA_W];
  assign out_data_s   = sk_out_s[DATA_W-1:0];

  // A read is launched only if the skid slot will be free when it returns
  assign issue_s      = (state_q == ST_FETCH) && !sk_full_next_s;
  assign last_issue_s = issue_s && (in_idx_q == IN_LAST) && (nrn_q == NRN_LAST);
  assign fire_s       = sk_valid_s && bus.w_ready;
  assign final_beat_s = fire_s && out_last_s && (out_nrn_s == NRN_LAST);

  // Sequencer next state, address counter and read tagging
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    in_idx_d  = in_idx_q;
    nrn_d     = nrn_q;
    skip_d    = skip_q;
    rd_pend_d = issue_s;
    rd_last_d = (in_idx_q == IN_LAST);
    rd_nrn_d  = nrn_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = ADDR_W'(wrc_layer_base(layer, N_NEURON, N_IN));
          in_idx_d = {IN_W{1'b0}};
          nrn_d    = 2'd0;
          skip_d   = 1'b0;
`ifdef WEIGHT_RAM_LAYER_CHECK_EN
          if (layer >= 2'(WRC_LAYER_CNT)) begin
            // Nonexistent layer: no reads, report done two cycles after start
            skip_d  = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FETCH;
          end
`else
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (last_issue_s) begin
          state_d = ST_DRAIN;
        end else if (issue_s) begin
          addr_d = addr_q + ADDR_ONE;
          if (in_idx_q == IN_LAST) begin
            in_idx_d = {IN_W{1'b0}};
            nrn_d    = nrn_q + 2'd1;
          end else begin
            in_idx_d = in_idx_q + IN_ONE;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (skip_q || final_beat_s) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FINISH: begin
        skip_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer, counter and read-tag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      in_idx_q  <= {IN_W{1'b0}};
      nrn_q     <= 2'd0;
      skip_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
      rd_nrn_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      in_idx_q  <= in_idx_d;
      nrn_q     <= nrn_d;
      skip_q    <= skip_d;
      rd_pend_q <= rd_pend_d;
      rd_last_q <= rd_last_d;
      rd_nrn_q  <= rd_nrn_d;
    end
  end

  // Outputs are forced to zero whenever no beat is presented
  assign bus.ram_addr   = addr_q;
  assign bus.ram_en     = issue_s;
  assign bus.w_valid    = sk_valid_s;
  assign bus.w_data     = sk_valid_s ? out_data_s : {DATA_W{1'b0}};
  assign bus.w_last     = sk_valid_s & out_last_s;
  assign bus.neuron_idx = sk_valid_s ? out_nrn_s : 2'd0;
  assign done           = (state_q == ST_FINISH);
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_weight_ram_controller.sv
// Self-checking bench for weight_ram_controller: a synchronous RAM model with
// random contents, and a reference list of (address, weight, last, neuron)
// built from the layer/neuron/input ordering rules.
module tb_weight_ram_controller;
  import weight_ram_controller_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int NI    = 4;
  localparam int NN    = 4;
  localparam int BEATS = NI * NN;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    nrn;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] layer;
  logic       done;
  logic       busy;

  weight_ram_controller_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

  weight_ram_controller #(.DATA_W(DW), .ADDR_W(AW), .N_IN(NI), .N_NEURON(NN)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .layer(layer),
    .done (done),
    .busy (busy),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Synchronous RAM: data appears one cycle after the enabled address
  always @(posedge clk) begin
    if (bus_if.ram_en) bus_if.ram_dout <= mem[bus_if.ram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  beat_t         exp_beats[$];
  logic [AW-1:0] exp_addr[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string ctx);
    check_eq({ctx, "_done"},       32'(done), 32'd0);
    check_eq({ctx, "_busy"},       32'(busy), 32'd0);
    check_eq({ctx, "_ram_en"},     32'(bus_if.ram_en), 32'd0);
    check_eq({ctx, "_ram_addr"},   32'(bus_if.ram_addr), 32'd0);
    check_eq({ctx, "_w_valid"},    32'(bus_if.w_valid), 32'd0);
    check_eq({ctx, "_w_data"},     32'(bus_if.w_data), 32'd0);
    check_eq({ctx, "_w_last"},     32'(bus_if.w_last), 32'd0);
    check_eq({ctx, "_neuron_idx"}, 32'(bus_if.neuron_idx), 32'd0);
  endtask

  // mode: 0 ready always, 1 five-cycle stall at beat 6, 2 toggling, 3 random
  task automatic run_layer(input logic [1:0] lyr, input int mode, input int dup_beat,
                           input int rst_beat, input bit start_at_done);
    int    beats = 0;
    int    done_cnt = 0;
    int    done_cyc = -1;
    int    first_valid = -1;
    int    stall_left = 0;
    int    total;
    bit    stalled_once = 1'b0;
    bit    dup_done = 1'b0;
    bit    rst_hit = 1'b0;
    bit    skip = 1'b0;
    beat_t b;
`ifdef WEIGHT_RAM_LAYER_CHECK_EN
    skip = (int'(lyr) >= WRC_LAYER_CNT);
`endif
    exp_beats.delete();
    exp_addr.delete();
    if (!skip) begin
      for (int n = 0; n < NN; n++) begin
        for (int i = 0; i < NI; i++) begin
          int a;
          a = (int'(lyr) * NN * NI + n * NI + i) % (1 << AW);
          exp_addr.push_back(AW'(a));
          b.data = mem[a];
          b.last = (i == NI - 1);
          b.nrn  = 2'(n);
          exp_beats.push_back(b);
        end
      end
    end
    total = exp_beats.size();

    @(posedge clk); #1;
    start = 1'b1;
    layer = lyr;
    bus_if.w_ready = 1'b1;
    @(negedge clk);
    check_eq("busy_before_accept", 32'(busy), 32'd0);

    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (dup_beat >= 0 && !dup_done && beats == dup_beat) begin
        start    = 1'b1;
        layer    = ~lyr;
        dup_done = 1'b1;
      end
      if (start_at_done && cyc == BEATS + 2) start = 1'b1;
      if (rst_beat >= 0 && beats == rst_beat) begin
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        reset   = 1'b0;
        rst_hit = 1'b1;
        break;
      end
      case (mode)
        0: bus_if.w_ready = 1'b1;
        1: begin
          if (!stalled_once && beats == 6) begin
            stall_left   = 5;
            stalled_once = 1'b1;
          end
          bus_if.w_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        2: bus_if.w_ready = (cyc % 2 == 0);
        default: bus_if.w_ready = 1'($urandom_range(0, 1));
      endcase

      @(negedge clk);
      if (done_cnt == 0) check_eq("busy_active", 32'(busy), 32'd1);
      if (bus_if.ram_en) begin
        if (exp_addr.size() == 0) check_eq("unexpected_ram_en", 32'(bus_if.ram_en), 32'd0);
        else check_eq("ram_addr", 32'(bus_if.ram_addr), 32'(exp_addr.pop_front()));
      end
      if (bus_if.w_valid && first_valid < 0) begin
        first_valid = cyc;
        if (mode == 0) check_eq("first_valid_cycle", 32'(cyc), 32'd2);
      end
      if (bus_if.w_valid && exp_beats.size() == 0)
        check_eq("unexpected_w_valid", 32'(bus_if.w_valid), 32'd0);
      if (bus_if.w_valid && bus_if.w_ready && exp_beats.size() != 0) begin
        b = exp_beats.pop_front();
        check_eq("w_data",     32'(bus_if.w_data), 32'(b.data));
        check_eq("w_last",     32'(bus_if.w_last), 32'(b.last));
        check_eq("neuron_idx", 32'(bus_if.neuron_idx), 32'(b.nrn));
        beats++;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          check_eq("beats_at_done", 32'(beats), 32'(total));
          if (mode == 0) check_eq("done_cycle", 32'(cyc), skip ? 32'd2 : 32'(BEATS + 2));
        end
      end
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
    end

    if (!rst_hit) begin
      check_eq("done_pulses", 32'(done_cnt), 32'd1);
      check_eq("busy_after",  32'(busy), 32'd0);
      check_eq("reads_left",  32'(exp_addr.size()), 32'd0);
      check_eq("beats_left",  32'(exp_beats.size()), 32'd0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    layer          = 2'd0;
    bus_if.w_ready = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");

    run_layer(2'd1, 0, -1, -1, 1'b0);  // full-rate layer 1
    run_layer(2'd0, 1, -1, -1, 1'b0);  // five-cycle stall at beat 6
    run_layer(2'd2, 0,  3, -1, 1'b0);  // extra start while busy
    run_layer(2'd2, 0, -1,  9, 1'b0);  // reset mid-layer
    repeat (2) @(negedge clk);
    check_reset_outputs("post_abort");
    run_layer(2'd0, 0, -1, -1, 1'b0);  // fresh transfer after abort
    run_layer(2'd3, 0, -1, -1, 1'b0);  // layer 3: skipped or fetched per build
    run_layer(2'd1, 2, -1, -1, 1'b0);  // toggling ready
    run_layer(2'd0, 0, -1, -1, 1'b1);  // start coincident with done
    for (int r = 0; r < 6; r++) begin
      run_layer(2'($urandom_range(0, 3)), 3, -1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/weight_ram_controller.md
WEIGHT_RAM_CONTROLLER -- requirements
Module: weight_ram_controller

Interface
REQ-001 Parameter DATA_W, default 8: width of one RAM word (weight).
REQ-002 Parameter ADDR_W, default 10: RAM address width.
REQ-003 Parameter N_IN, default 4: inputs (weights) per neuron.
REQ-004 Parameter N_NEURON, default 4: neurons per layer.
REQ-005 Port clk  input  1: single clock; all state on rising edge.
REQ-006 Port reset  input  1: asynchronous, active-high reset.
REQ-007 Port start  input  1: RAM_Controll_Start from Network_Controller; one-cycle pulse begins a layer fetch.
REQ-008 Port layer  input  2: layer index, sampled only on the accepted start.
REQ-009 Port ram_addr  output  ADDR_W: synchronous RAM read address.
REQ-010 Port ram_en  output  1: RAM read enable.
REQ-011 Port ram_dout  input  DATA_W: RAM read data, valid exactly one cycle after ram_en.
REQ-012 Port w_data  output  DATA_W: weight presented to MultiSum.
REQ-013 Port w_valid  output  1: w_data valid.
REQ-014 Port w_ready  input  1: MultiSum accepts w_data when w_valid && w_ready.
REQ-015 Port w_last  output  1: w_data is the final weight of the current neuron.
REQ-016 Port neuron_idx  output  2: neuron the current w_data belongs to.
REQ-017 Port done  output  1: one-cycle pulse to Network_Controller when the whole layer is transferred.
REQ-018 Port busy  output  1: high from accepted start until done.

Function
REQ-019 FSM states IDLE, FETCH, DRAIN, FINISH; IDLE -> FETCH on start; FETCH -> DRAIN when final address issued; DRAIN -> FINISH when final beat accepted; FINISH -> IDLE after one cycle.
REQ-020 Address = layer*N_NEURON*N_IN + neuron*N_IN + input, computed in ADDR_W bits, input index innermost.
REQ-021 First ram_en asserted the cycle after start is accepted; one address per cycle while no stall.
REQ-022 A 1-entry skid buffer holds read data returning while w_ready is low; no beat lost or duplicated.
REQ-023 ram_en deasserts (address held) whenever the skid buffer is full and output is stalled.
REQ-024 Zero-stall throughput one beat per cycle; start-to-first-w_valid latency 2 cycles.
REQ-025 w_last high on input index N_IN-1; neuron_idx matches the beat, not the in-flight address.
REQ-026 done pulses in FINISH, exactly one cycle, after the N_IN*N_NEURON-th handshake.
REQ-027 start while busy ignored; layer not resampled.
REQ-028 start coincident with done pulse ignored; next start accepted from IDLE.

Reset
REQ-029 On reset (any time, including mid-layer): state IDLE, ram_addr=0, ram_en=0, w_data=0, w_valid=0, w_last=0, neuron_idx=0, done=0, busy=0, skid empty.
REQ-030 First start after reset deassertion proceeds normally; no partial transfer resumes.

Configuration
REQ-031 Macro WEIGHT_RAM_LAYER_CHECK_EN defined: layer >= 3 on start issues no RAM reads and pulses done two cycles after start with w_valid never asserted.
REQ-032 Macro undefined: no check; layer 3 fetched like any other, address wrapping modulo 2^ADDR_W.

Structure
REQ-033 Shared package holds FSM state encoding, DATA_W/ADDR_W defaults and the layer-count constant (3), used also by Network_Controller.
REQ-034 Skid buffer is one sub-module, weight_skid_buf; address counter and FSM stay in the top.

Verification
REQ-035 Reset, start with layer=1, w_ready=1 -> addresses 16..31 in order, 16 beats, w_last on beats 4/8/12/16, done pulse 18 cycles after start.
REQ-036 Layer 0, w_ready low for 5 cycles at beat 6 -> no lost/duplicated beat, data equals RAM contents 0..15 in order.
REQ-037 Start pulsed again at beat 3 of layer 2 -> ignored, exactly 16 beats from addresses 32..47, single done.
REQ-038 Reset asserted at beat 9 -> all outputs 0 same cycle; next start layer=0 yields beats from address 0.
REQ-039 With WEIGHT_RAM_LAYER_CHECK_EN, start layer=3 -> ram_en never high, done pulse at start+2; without macro -> addresses 48..63 fetched.
REQ-040 w_ready toggling every cycle across a full layer -> 16 beats, neuron_idx 0,0,0,0,1,...,3 aligned to beats.
